// File: rtl/hs_unit_pipe_reg.sv
// rtl/hs_unit_pipe_reg.sv - elastic valid/ready pipeline register chain with optional skid slices
module hs_unit_pipe_reg #(
  parameter type      DATA_TYPE   = logic,
  parameter int       STAGES      = 1,
  parameter int       SKID        = 0,
  parameter int       RESET_DATA  = 0,
  parameter DATA_TYPE RESET_VALUE = '0,
  parameter int       CNT_W       = (STAGES * (1 + SKID) > 0) ? $clog2(STAGES * (1 + SKID) + 1) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  DATA_TYPE         in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output DATA_TYPE         out_data,
  output logic [CNT_W-1:0] count
);

  if (STAGES == 0) begin : g_pass
    // Zero-depth pipe: wires only, nothing is ever held.
    assign out_valid = in_valid;
    assign out_data  = in_data;
    assign in_ready  = out_ready && !rst;
    assign count     = '0;
  end else begin : g_pipe
    for (genvar k = 0; k < STAGES; k++) begin : g_slice
      // Per-slice boundary signals; neighbours are linked by hierarchical name
      // so the ready chain never loops through a single vector.
      logic             vld_in;
      DATA_TYPE         dat_in;
      logic             rdy_up;
      logic             dn_rdy;
      logic             vld_out;
      DATA_TYPE         dat_out;
      logic [1:0]       occ;
      logic [CNT_W-1:0] cnt_prev;
      logic [CNT_W-1:0] cnt_acc;

      if (k == 0) begin : g_first
        assign vld_in   = in_valid;
        assign dat_in   = in_data;
        assign cnt_prev = '0;
      end else begin : g_next
        assign vld_in   = g_slice[k-1].vld_out;
        assign dat_in   = g_slice[k-1].dat_out;
        assign cnt_prev = g_slice[k-1].cnt_acc;
      end

      if (k == STAGES - 1) begin : g_last
        assign dn_rdy = out_ready;
      end else begin : g_mid
        assign dn_rdy = g_slice[k+1].rdy_up;
      end

      // Running occupancy: each slice adds its own valid entries.
      assign cnt_acc = cnt_prev + CNT_W'(occ);

      if (SKID == 0) begin : g_fwd
        logic     v_q, v_d;
        DATA_TYPE dat_q, dat_d;
        logic     acc;

        assign rdy_up  = !v_q || dn_rdy;
        assign acc     = vld_in && rdy_up;
        assign vld_out = v_q;
        assign dat_out = dat_q;
        assign occ     = {1'b0, v_q};

        // Next state: load on accept, empty when downstream drains us.
        always_comb begin
          v_d   = v_q;
          dat_d = dat_q;
          if (acc) begin
            v_d   = 1'b1;
            dat_d = dat_in;
          end else if (dn_rdy) begin
            v_d = 1'b0;
          end
        end

        // Valid flag register, always reset.
        always_ff @(posedge clk) begin
          if (rst) v_q <= 1'b0;
          else     v_q <= v_d;
        end

        // Payload register, reset only when configured to.
        always_ff @(posedge clk) begin
          if (rst && RESET_DATA != 0) dat_q <= RESET_VALUE;
          else                        dat_q <= dat_d;
        end
      end else begin : g_skid
        logic     m_v_q, m_v_d, s_v_q, s_v_d;
        DATA_TYPE m_dat_q, m_dat_d, s_dat_q, s_dat_d;
        logic     acc;
        logic     take;

        // Upstream ready comes straight from the skid flag flop.
        assign rdy_up  = !s_v_q;
        assign acc     = vld_in && !s_v_q;
        assign take    = m_v_q && dn_rdy;
        assign vld_out = m_v_q;
        assign dat_out = m_dat_q;
        assign occ     = {1'b0, m_v_q} + {1'b0, s_v_q};

        // Next state: refill main from skid first, else from the input;
        // a beat arriving while main is stuck parks in the skid entry.
        always_comb begin
          m_v_d   = m_v_q;
          s_v_d   = s_v_q;
          m_dat_d = m_dat_q;
          s_dat_d = s_dat_q;
          if (!m_v_q || take) begin
            if (s_v_q) begin
              m_v_d   = 1'b1;
              m_dat_d = s_dat_q;
              s_v_d   = 1'b0;
            end else begin
              m_v_d = acc;
              if (acc) m_dat_d = dat_in;
            end
          end else if (acc) begin
            s_v_d   = 1'b1;
            s_dat_d = dat_in;
          end
        end

        // Valid flag registers, always reset.
        always_ff @(posedge clk) begin
          if (rst) begin
            m_v_q <= 1'b0;
            s_v_q <= 1'b0;
          end else begin
            m_v_q <= m_v_d;
            s_v_q <= s_v_d;
          end
        end

        // Payload registers, reset only when configured to.
        always_ff @(posedge clk) begin
          if (rst && RESET_DATA != 0) begin
            m_dat_q <= RESET_VALUE;
            s_dat_q <= RESET_VALUE;
          end else begin
            m_dat_q <= m_dat_d;
            s_dat_q <= s_dat_d;
          end
        end
      end
    end

    assign out_valid = g_slice[STAGES-1].vld_out;
    assign out_data  = g_slice[STAGES-1].dat_out;
    assign in_ready  = g_slice[0].rdy_up && !rst;
    assign count     = g_slice[STAGES-1].cnt_acc;
  end

endmodule

// File: tb/tb_hs_unit_pipe_reg.sv
// tb/tb_hs_unit_pipe_reg.sv - bench for hs_unit_pipe_reg over five configurations
module tb_hs_unit_pipe_reg;

  // dut0: 3 fwd, dut1: 2 skid + data reset 0x3C, dut2: 4 fwd, dut3: 4 skid, dut4: passthrough
  logic       clk;
  logic       rst  [5];
  logic       iv   [5];
  logic       ir   [5];
  logic       ov   [5];
  logic       ordy [5];
  logic [7:0] id   [5];
  logic [7:0] od   [5];
  logic [1:0] c0;
  logic [2:0] c1, c2;
  logic [3:0] c3;
  logic       c4;
  int         cnt  [5];

  int total, bad;
  int maxc [5];
  bit skid [5];

  // scoreboard: accepted beats in order, per DUT
  logic [7:0] sb [5][128];
  int         wp [5];
  int         rp [5];
  logic       stall_q [5];
  logic [7:0] stall_d [5];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    cnt[0] = int'(c0);
    cnt[1] = int'(c1);
    cnt[2] = int'(c2);
    cnt[3] = int'(c3);
    cnt[4] = int'(c4);
  end

  hs_unit_pipe_reg #(.DATA_TYPE(logic [7:0]), .STAGES(3), .SKID(0)) u_d0 (
    .clk(clk), .rst(rst[0]), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]), .count(c0));
  hs_unit_pipe_reg #(.DATA_TYPE(logic [7:0]), .STAGES(2), .SKID(1), .RESET_DATA(1),
                     .RESET_VALUE(8'h3C)) u_d1 (
    .clk(clk), .rst(rst[1]), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]), .count(c1));
  hs_unit_pipe_reg #(.DATA_TYPE(logic [7:0]), .STAGES(4), .SKID(0)) u_d2 (
    .clk(clk), .rst(rst[2]), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(id[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od[2]), .count(c2));
  hs_unit_pipe_reg #(.DATA_TYPE(logic [7:0]), .STAGES(4), .SKID(1)) u_d3 (
    .clk(clk), .rst(rst[3]), .in_valid(iv[3]), .in_ready(ir[3]), .in_data(id[3]),
    .out_valid(ov[3]), .out_ready(ordy[3]), .out_data(od[3]), .count(c3));
  hs_unit_pipe_reg #(.DATA_TYPE(logic [7:0]), .STAGES(0), .SKID(0)) u_d4 (
    .clk(clk), .rst(rst[4]), .in_valid(iv[4]), .in_ready(ir[4]), .in_data(id[4]),
    .out_valid(ov[4]), .out_ready(ordy[4]), .out_data(od[4]), .count(c4));

  task automatic chk(input string nm, input int i, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s dut%0d: got %0h want %0h (t=%0t)", nm, i, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle compare against the queue model, sampled mid-cycle before the edge.
  always @(negedge clk) begin
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin
        chk("pt_valid", i, int'(ov[i]), int'(iv[i]));
        chk("pt_data",  i, int'(od[i]), int'(id[i]));
        chk("pt_ready", i, int'(ir[i]), int'(ordy[i] && !rst[i]));
        chk("pt_count", i, cnt[i], 0);
      end else begin
        chk("count", i, cnt[i], wp[i] - rp[i]);
        chk("count_max", i, int'(cnt[i] <= maxc[i]), 1);
        chk("spurious_valid", i, int'(ov[i] && (wp[i] == rp[i])), 0);
        if (ov[i] && (wp[i] != rp[i]))
          chk("order", i, int'(od[i]), int'(sb[i][rp[i][6:0]]));
        if (stall_q[i]) begin
          chk("hold_valid", i, int'(ov[i]), 1);
          chk("hold_data",  i, int'(od[i]), int'(stall_d[i]));
        end
        if (rst[i])
          chk("rst_ready", i, int'(ir[i]), 0);
        if (!skid[i] && cnt[i] == maxc[i] && !ordy[i])
          chk("full_ready_fwd", i, int'(ir[i]), 0);
        if (skid[i] && cnt[i] == maxc[i])
          chk("full_ready_skid", i, int'(ir[i]), 0);
        if (cnt[i] == 0 && !rst[i])
          chk("empty_ready", i, int'(ir[i]), 1);
        if (rst[i]) begin
          wp[i] = 0;
          rp[i] = 0;
          stall_q[i] = 1'b0;
        end else begin
          if (iv[i] && ir[i]) begin
            sb[i][wp[i][6:0]] = id[i];
            wp[i]++;
          end
          if (ov[i] && ordy[i]) rp[i]++;
          stall_q[i] = ov[i] && !ordy[i];
          stall_d[i] = od[i];
        end
      end
    end
  end

  initial begin
    int nx, acc, expv, found;
    int seq [5];
    total = 0;
    bad   = 0;
    maxc  = '{3, 4, 4, 8, 0};
    skid  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      rst[i] = 1'b1; iv[i] = 1'b0; id[i] = 8'h00; ordy[i] = 1'b0;
      wp[i] = 0; rp[i] = 0; stall_q[i] = 1'b0; stall_d[i] = 8'h00; seq[i] = 0;
    end

    // reset state
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("reset_ready_low", i, int'(ir[i]), 0);
      chk("reset_valid",     i, int'(ov[i]), 0);
      chk("reset_count",     i, cnt[i], 0);
    end
    for (int i = 0; i < 5; i++) rst[i] = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) chk("post_reset_ready", i, int'(ir[i]), 1);

    // latency: 3 forward slices, single beat 0xA5
    iv[0] = 1'b1; id[0] = 8'hA5; ordy[0] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      iv[0] = 1'b0;
      #1;
      chk("lat_valid", 0, int'(ov[0]), (c == 2) ? 1 : 0);
      chk("lat_count", 0, cnt[0], (c < 3) ? 1 : 0);
      if (c == 2) chk("lat_data", 0, int'(od[0]), 8'hA5);
    end

    // passthrough
    iv[4] = 1'b1; id[4] = 8'h55; ordy[4] = 1'b0;
    #1;
    chk("pt_lit_valid", 4, int'(ov[4]), 1);
    chk("pt_lit_data",  4, int'(od[4]), 8'h55);
    chk("pt_lit_ready", 4, int'(ir[4]), 0);
    chk("pt_lit_count", 4, cnt[4], 0);
    ordy[4] = 1'b1;
    #1;
    chk("pt_lit_ready_hi", 4, int'(ir[4]), 1);
    iv[4] = 1'b0;
    tick();

    // streaming 0..99 through two skid slices
    ordy[1] = 1'b1;
    for (int c = 0; c < 102; c++) begin
      iv[1] = (c < 100);
      id[1] = 8'(c);
      #1;
      chk("stream_ready", 1, int'(ir[1]), 1);
      chk("stream_valid", 1, int'(ov[1]), (c >= 2) ? 1 : 0);
      if (c >= 2) chk("stream_data", 1, int'(od[1]), c - 2);
      tick();
    end
    iv[1] = 1'b0;

    // stall and skid: 4 beats fit with out_ready low
    ordy[1] = 1'b0;
    nx  = 1;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      iv[1] = 1'b1;
      id[1] = 8'(nx);
      #1;
      if (ir[1]) begin
        nx++;
        acc++;
      end
      tick();
    end
    id[1] = 8'(nx);
    #1;
    chk("stall_accepts", 1, acc, 4);
    chk("stall_count",   1, cnt[1], 4);
    chk("stall_ready",   1, int'(ir[1]), 0);
    chk("stall_valid",   1, int'(ov[1]), 1);
    chk("stall_data",    1, int'(od[1]), 1);
    ordy[1] = 1'b1;
    #1;
    chk("skid_ready_same_cycle", 1, int'(ir[1]), 0);
    expv = 1;
    for (int c = 0; c < 20; c++) begin
      iv[1] = (nx <= 12);
      id[1] = 8'(nx);
      #1;
      if (ov[1]) begin
        chk("drain_data", 1, int'(od[1]), expv);
        expv++;
      end
      if (iv[1] && ir[1]) nx++;
      tick();
    end
    chk("drain_all", 1, expv, 13);
    iv[1] = 1'b0;

    // mid-stream reset with three beats held
    ordy[1] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      iv[1] = 1'b1;
      id[1] = 8'(8'h10 + c);
      #1;
      tick();
    end
    iv[1] = 1'b0;
    #1;
    chk("mid_count", 1, cnt[1], 3);
    rst[1] = 1'b1;
    #1;
    chk("mid_rst_ready", 1, int'(ir[1]), 0);
    tick();
    rst[1] = 1'b0;
    #1;
    chk("mid_post_valid", 1, int'(ov[1]), 0);
    chk("mid_post_count", 1, cnt[1], 0);
    chk("mid_post_data",  1, int'(od[1]), 8'h3C);
    iv[1] = 1'b1; id[1] = 8'h7E; ordy[1] = 1'b1;
    #1;
    chk("mid_accept_ready", 1, int'(ir[1]), 1);
    tick();
    iv[1] = 1'b0;
    found = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (ov[1] && found == 0) begin
        chk("first_after_rst", 1, int'(od[1]), 8'h7E);
        found = 1;
      end
      tick();
    end
    chk("first_seen", 1, found, 1);

    // random backpressure on 4-deep forward and skid pipes
    for (int c = 0; c < 10000; c++) begin
      for (int i = 2; i < 4; i++) begin
        iv[i]   = ($urandom_range(0, 3) != 0);
        ordy[i] = (c < 3000) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0);
        id[i]   = 8'(seq[i]);
      end
      #1;
      for (int i = 2; i < 4; i++)
        if (iv[i] && ir[i]) seq[i]++;
      tick();
    end
    for (int i = 2; i < 4; i++) begin
      iv[i] = 1'b0;
      ordy[i] = 1'b1;
    end
    for (int c = 0; c < 20; c++) tick();
    for (int i = 2; i < 4; i++) begin
      chk("rand_drained", i, cnt[i], 0);
      chk("rand_all_out", i, rp[i], seq[i]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
